sprite_anim_ctrl: RTL and testbench

//  Sequences the 4-frame 32x32 sprite animation and generates per-pixel lookup addresses for the

---
 rtl/sprite_anim_ctrl.sv | 138 +++++++++++++
 tb/tb_sprite_anim_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation sequencer: vblank-paced frame stepping with a play/stop FSM that always
// parks on frame 0, plus a one-stage beam-to-texel address pipeline for the frame LUT.
module sprite_anim_ctrl #(
    parameter int NUM_FRAMES = 4,
    parameter int SCALE_LOG2 = 2,
    parameter int HOLD_W     = 4,
    parameter int POS_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              play,
    input  logic              stop_req,
    input  logic [HOLD_W-1:0] hold,
    input  logic [POS_W-1:0]  hpos,
    input  logic [POS_W-1:0]  vpos,
    input  logic [POS_W-1:0]  spr_x,
    input  logic [POS_W-1:0]  spr_y,
    output logic [4:0]        lut_x,
    output logic [4:0]        lut_y,
    output logic [1:0]        lut_frame,
    output logic              pix_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0]     LAST_FRAME = 2'(NUM_FRAMES - 1);
    localparam logic [POS_W:0] BOX_SPAN   = (POS_W + 1)'(32 << SCALE_LOG2);

    state_t            state_q, state_d;
    logic [1:0]        frame_sel_q, frame_sel_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hmax_s;
    logic              adv_s;
    logic              frame_end_s;
    logic [POS_W:0]    dx_s;
    logic [POS_W:0]    dy_s;
    logic              inside_s;
    logic [4:0]        lut_x_q, lut_y_q;
    logic [1:0]        lut_frame_q;
    logic              pix_valid_q;
    logic              busy_q;

    // ">=" lets a hold reduced mid-count end the frame on the next tick instead of overrunning
    assign hmax_s      = (hold == '0) ? HOLD_W'(1) : hold;
    assign adv_s       = frame_tick && (state_q != ST_IDLE);
    assign frame_end_s = (hold_cnt_q >= (hmax_s - HOLD_W'(1)));

    // MSB of the extended difference flags a beam left of / above the sprite origin
    assign dx_s     = {1'b0, hpos} - {1'b0, spr_x};
    assign dy_s     = {1'b0, vpos} - {1'b0, spr_y};
    assign inside_s = !dx_s[POS_W] && !dy_s[POS_W] && (dx_s < BOX_SPAN) && (dy_s < BOX_SPAN);

    // Next-state: frame advance first, then play/stop transitions judged on post-advance values
    always_comb begin
        state_d     = state_q;
        frame_sel_d = frame_sel_q;
        hold_cnt_d  = hold_cnt_q;
        if (adv_s) begin
            if (frame_end_s) begin
                hold_cnt_d  = '0;
                frame_sel_d = (frame_sel_q == LAST_FRAME) ? 2'd0 : frame_sel_q + 2'd1;
            end else begin
                hold_cnt_d  = hold_cnt_q + HOLD_W'(1);
            end
        end else begin
            hold_cnt_d  = hold_cnt_q;
            frame_sel_d = frame_sel_q;
        end
        case (state_q)
            ST_IDLE: begin
                frame_sel_d = 2'd0;
                hold_cnt_d  = '0;
                if (play) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop_req) begin
                    state_d = ((frame_sel_d == 2'd0) && (hold_cnt_d == '0)) ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_DRAIN: begin
                if (adv_s && frame_end_s && (frame_sel_d == 2'd0)) begin
                    state_d = ST_IDLE;
                end else if (play && !stop_req) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                frame_sel_d = 2'd0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // State registers and registered LUT-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_sel_q <= 2'd0;
            hold_cnt_q  <= '0;
            lut_x_q     <= 5'd0;
            lut_y_q     <= 5'd0;
            lut_frame_q <= 2'd0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_sel_q <= frame_sel_d;
            hold_cnt_q  <= hold_cnt_d;
            lut_x_q     <= inside_s ? dx_s[SCALE_LOG2 +: 5] : 5'd0;
            lut_y_q     <= inside_s ? dy_s[SCALE_LOG2 +: 5] : 5'd0;
            lut_frame_q <= frame_sel_q;
            pix_valid_q <= inside_s;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign lut_x     = lut_x_q;
    assign lut_y     = lut_y_q;
    assign lut_frame = lut_frame_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Scoreboard bench for sprite_anim_ctrl: a behavioural model predicts each cycle's outputs into a
// queue; an independent monitor pops and compares one cycle later.
module tb_sprite_anim_ctrl;

    localparam int NF    = 4;
    localparam int SCALE = 2;
    localparam int BOX   = 32 << SCALE;

    localparam int MD_IDLE  = 0;
    localparam int MD_PLAY  = 1;
    localparam int MD_DRAIN = 2;

    typedef struct {
        logic [4:0] lx;
        logic [4:0] ly;
        logic [1:0] lf;
        logic       pv;
        logic       bz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, play, stop_req;
    logic [3:0] hold;
    logic [9:0] hpos, vpos, spr_x, spr_y;
    logic [4:0] lut_x, lut_y;
    logic [1:0] lut_frame;
    logic       pix_valid, busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    int m_mode  = MD_IDLE;
    int m_frame = 0;
    int m_cnt   = 0;

    sprite_anim_ctrl #(.NUM_FRAMES(NF), .SCALE_LOG2(SCALE), .HOLD_W(4), .POS_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .play(play), .stop_req(stop_req),
        .hold(hold), .hpos(hpos), .vpos(vpos), .spr_x(spr_x), .spr_y(spr_y),
        .lut_x(lut_x), .lut_y(lut_y), .lut_frame(lut_frame), .pix_valid(pix_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Predict post-edge outputs from current inputs, queue them, then advance one clock.
    task automatic cycle();
        exp_t e;
        int   dx, dy, hm, nf, nc;
        bit   ins;
        if (!rst_n) begin
            m_mode = MD_IDLE; m_frame = 0; m_cnt = 0;
            e = '{lx: 5'd0, ly: 5'd0, lf: 2'd0, pv: 1'b0, bz: 1'b0};
        end else begin
            dx  = int'(hpos) - int'(spr_x);
            dy  = int'(vpos) - int'(spr_y);
            ins = (dx >= 0) && (dx < BOX) && (dy >= 0) && (dy < BOX);
            e.lx = ins ? 5'(dx / (1 << SCALE)) : 5'd0;
            e.ly = ins ? 5'(dy / (1 << SCALE)) : 5'd0;
            e.pv = ins;
            e.lf = 2'(m_frame);
            hm = (hold == 4'd0) ? 1 : int'(hold);
            nf = m_frame;
            nc = m_cnt;
            if (m_mode != MD_IDLE && frame_tick) begin
                if (m_cnt + 1 >= hm) begin
                    nc = 0;
                    nf = (m_frame + 1) % NF;
                end else begin
                    nc = m_cnt + 1;
                end
            end
            case (m_mode)
                MD_IDLE: begin
                    nf = 0; nc = 0;
                    if (play) m_mode = MD_PLAY;
                end
                MD_PLAY: begin
                    if (stop_req) m_mode = (nf == 0 && nc == 0) ? MD_IDLE : MD_DRAIN;
                end
                default: begin
                    if (frame_tick && nf == 0 && m_frame != 0) m_mode = MD_IDLE;
                    else if (play && !stop_req) m_mode = MD_PLAY;
                end
            endcase
            m_frame = nf;
            m_cnt   = nc;
            e.bz    = (m_mode != MD_IDLE);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic go_idle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        int v;
        frame_tick = ($urandom_range(0, 3) == 0);
        play       = ($urandom_range(0, 9) == 0);
        stop_req   = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 30) == 0) hold = 4'($urandom_range(0, 5));
        if ($urandom_range(0, 200) == 0) begin
            spr_x = 10'($urandom_range(0, 1023));
            spr_y = 10'($urandom_range(0, 1023));
        end
        v = int'(spr_x) + int'($urandom_range(0, 140)) - 6;
        hpos = 10'(v);
        v = int'(spr_y) + int'($urandom_range(0, 140)) - 6;
        vpos = 10'(v);
    endtask

    // Monitor: compares DUT outputs against the oldest prediction just after each rising edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_lut_x", 32'(lut_x), 32'(e.lx));
                chk("sb_lut_y", 32'(lut_y), 32'(e.ly));
                chk("sb_lut_frame", 32'(lut_frame), 32'(e.lf));
                chk("sb_pix_valid", 32'(pix_valid), 32'(e.pv));
                chk("sb_busy", 32'(busy), 32'(e.bz));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int seq[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
        rst_n = 1'b0; frame_tick = 1'b0; play = 1'b0; stop_req = 1'b0; hold = 4'd0;
        hpos = 10'd0; vpos = 10'd0; spr_x = 10'd100; spr_y = 10'd50;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_lut_x", 32'(lut_x), 32'd0);
        chk("rst_lut_frame", 32'(lut_frame), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cycle();

        // hold=2: frame advances on every second tick, wrapping 3 -> 0
        hold = 4'd2; play = 1'b1; cycle(); play = 1'b0;
        for (int k = 0; k < 8; k++) begin
            frame_tick = 1'b1; cycle(); frame_tick = 1'b0; cycle();
            chk("t2_frame_seq", 32'(lut_frame), 32'(seq[k]));
        end

        // hold=0 advances every tick; hold 4->1 with count at 2 advances on the next tick
        go_idle();
        hold = 4'd0; play = 1'b1; cycle(); play = 1'b0;
        repeat (6) begin frame_tick = 1'b1; cycle(); end
        go_idle();
        hold = 4'd4; play = 1'b1; frame_tick = 1'b0; cycle(); play = 1'b0;
        frame_tick = 1'b1; cycle(); cycle();
        hold = 4'd1; cycle(); frame_tick = 1'b0; cycle();
        chk("t3_hold_shrink", 32'(lut_frame), 32'd1);

        // stop at frame 2 drains through 3 back to 0; stop at frame 0/count 0 idles at once
        go_idle();
        hold = 4'd1; play = 1'b1; cycle(); play = 1'b0;
        frame_tick = 1'b1; cycle(); cycle(); frame_tick = 1'b0;
        stop_req = 1'b1; cycle();
        chk("t4_drain_busy", 32'(busy), 32'd1);
        stop_req = 1'b0; frame_tick = 1'b1; cycle(); cycle(); frame_tick = 1'b0;
        chk("t4_drain_done", 32'(busy), 32'd0);
        go_idle();
        play = 1'b1; cycle(); play = 1'b0; stop_req = 1'b1; cycle(); stop_req = 1'b0;
        chk("t4_stop_at_zero", 32'(busy), 32'd0);

        // play+stop: IDLE goes to PLAY, PLAY obeys stop, play in DRAIN resumes with frame kept
        go_idle();
        hold = 4'd3; play = 1'b1; stop_req = 1'b1; cycle();
        chk("t5_idle_play_wins", 32'(busy), 32'd1);
        play = 1'b0; stop_req = 1'b0; frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
        play = 1'b1; stop_req = 1'b1; cycle();
        play = 1'b1; stop_req = 1'b0; frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
        play = 1'b0; repeat (3) cycle();
        chk("t5_drain_resume", 32'(busy), 32'd1);

        // address path boundaries around sprite at (100,50)
        spr_x = 10'd100; spr_y = 10'd50;
        hpos = 10'd100; vpos = 10'd50; cycle();
        chk("t6_origin_valid", 32'(pix_valid), 32'd1);
        chk("t6_origin_x", 32'(lut_x), 32'd0);
        hpos = 10'd227; cycle();
        chk("t6_right_x", 32'(lut_x), 32'd31);
        hpos = 10'd228; cycle();
        chk("t6_right_excl", 32'(pix_valid), 32'd0);
        hpos = 10'd99; cycle();
        chk("t6_left_out", 32'(pix_valid), 32'd0);
        spr_x = 10'd1000; hpos = 10'd3; vpos = 10'd60; cycle();
        chk("t6_no_wrap", 32'(pix_valid), 32'd0);

        // randomized traffic
        spr_x = 10'd100; hold = 4'd2;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        // asynchronous reset while playing clears outputs immediately
        play = 1'b1; stop_req = 1'b0; hold = 4'd3; cycle(); play = 1'b0;
        repeat (5) begin rand_inputs(); stop_req = 1'b0; cycle(); end
        hpos = spr_x; vpos = spr_y; cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_async_lut_x", 32'(lut_x), 32'd0);
        chk("rst_async_lut_y", 32'(lut_y), 32'd0);
        chk("rst_async_frame", 32'(lut_frame), 32'd0);
        chk("rst_async_valid", 32'(pix_valid), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        repeat (2) begin rand_inputs(); cycle(); end
        rst_n = 1'b1; play = 1'b0;
        repeat (3) begin rand_inputs(); play = 1'b0; cycle(); end

        frame_tick = 1'b0; play = 1'b0; stop_req = 1'b0;
        cycle();
        @(posedge clk);
        #2;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
